biriscv_npc_update_arb: RTL and testbench

Arbitrates branch-resolution reports from the two issue pipes into the single update port of the next-PC predictor (BTB/BHT/RAS).
- Mispredict redirects pass through combinationally, zero latency.
- Training-only reports (correctly predicted branches) are buffered in a small FIFO and drained one per cycle.
- On invalidate, sequences a walk that clears every BHT counter.

---
 rtl/biriscv_npc_update_arb_if.sv | 69 ++++++
 rtl/biriscv_npc_update_arb.sv | 206 ++++++++++++++++++++
 tb/tb_biriscv_npc_update_arb.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/biriscv_npc_update_arb_if.sv
// Branch-resolution report bundle between the issue pipes and the
// next-PC predictor update port.
interface biriscv_npc_update_arb_if #(
  parameter int NUM_BHT_ENTRIES_W = 9
);
  logic        invalidate_i;

  logic        p0_valid_i;
  logic        p0_mispredict_i;
  logic        p0_taken_i;
  logic [31:0] p0_source_i;
  logic [31:0] p0_target_i;
  logic        p0_is_call_i;
  logic        p0_is_ret_i;
  logic        p0_is_jmp_i;

  logic        p1_valid_i;
  logic        p1_mispredict_i;
  logic        p1_taken_i;
  logic [31:0] p1_source_i;
  logic [31:0] p1_target_i;
  logic        p1_is_call_i;
  logic        p1_is_ret_i;
  logic        p1_is_jmp_i;

  logic        branch_request_o;
  logic        branch_is_taken_o;
  logic        branch_is_not_taken_o;
  logic [31:0] branch_source_o;
  logic [31:0] branch_pc_o;
  logic        branch_is_call_o;
  logic        branch_is_ret_o;
  logic        branch_is_jmp_o;

  logic                         bht_clear_o;
  logic [NUM_BHT_ENTRIES_W-1:0] bht_clear_idx_o;
  logic                         busy_o;
  logic [15:0]                  drop_count_o;

  modport master (
    output invalidate_i,
    output p0_valid_i, p0_mispredict_i, p0_taken_i,
    output p0_source_i, p0_target_i,
    output p0_is_call_i, p0_is_ret_i, p0_is_jmp_i,
    output p1_valid_i, p1_mispredict_i, p1_taken_i,
    output p1_source_i, p1_target_i,
    output p1_is_call_i, p1_is_ret_i, p1_is_jmp_i,
    input  branch_request_o, branch_is_taken_o,
    input  branch_is_not_taken_o,
    input  branch_source_o, branch_pc_o,
    input  branch_is_call_o, branch_is_ret_o, branch_is_jmp_o,
    input  bht_clear_o, bht_clear_idx_o, busy_o, drop_count_o
  );

  modport slave (
    input  invalidate_i,
    input  p0_valid_i, p0_mispredict_i, p0_taken_i,
    input  p0_source_i, p0_target_i,
    input  p0_is_call_i, p0_is_ret_i, p0_is_jmp_i,
    input  p1_valid_i, p1_mispredict_i, p1_taken_i,
    input  p1_source_i, p1_target_i,
    input  p1_is_call_i, p1_is_ret_i, p1_is_jmp_i,
    output branch_request_o, branch_is_taken_o,
    output branch_is_not_taken_o,
    output branch_source_o, branch_pc_o,
    output branch_is_call_o, branch_is_ret_o, branch_is_jmp_o,
    output bht_clear_o, bht_clear_idx_o, busy_o, drop_count_o
  );
endinterface

// File: rtl/biriscv_npc_update_arb.sv
// Next-PC predictor update arbiter: mispredicts pass straight through,
// training reports queue in a small FIFO, invalidate walks the BHT.
module biriscv_npc_update_arb #(
  parameter int FIFO_DEPTH        = 4,
  parameter int FIFO_DEPTH_W      = 2,
  parameter int NUM_BHT_ENTRIES   = 512,
  parameter int NUM_BHT_ENTRIES_W = 9
) (
  input logic                     clk_i,
  input logic                     rst_i,
  biriscv_npc_update_arb_if.slave bus
);

  localparam int PW = FIFO_DEPTH_W;
  localparam int KW = FIFO_DEPTH_W + 1;
  localparam int CW = FIFO_DEPTH_W + 2;
  localparam int IW = NUM_BHT_ENTRIES_W;
  localparam logic [IW-1:0] LAST = IW'(NUM_BHT_ENTRIES - 1);

  typedef struct packed {
    logic        taken;
    logic [31:0] source;
    logic [31:0] target;
    logic        is_call;
    logic        is_ret;
    logic        is_jmp;
  } entry_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  entry_t          p0_e;
  entry_t          p1_e;
  entry_t          head_e;
  entry_t          first_e;
  entry_t          out_e;
  entry_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0]   rd_ptr_q;
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   wr_nxt;
  logic [KW-1:0]   count_q;
  logic [15:0]     drop_q;
  logic [16:0]     drop_sum;
  state_t          state_q;
  state_t          state_d;
  logic [IW-1:0]   idx_q;
  logic [IW-1:0]   idx_d;

  logic            p0m;
  logic            p1m;
  logic            fwd0;
  logic            fwd1;
  logic            cand0;
  logic            cand1;
  logic            idle;
  logic            pop;
  logic            accept;
  logic [1:0]      n_cand;
  logic [1:0]      n_push;
  logic [1:0]      n_drop;
  logic [CW-1:0]   free_slots;
  logic            push0;
  logic            push1;
  logic            out_req;
  logic            out_vld;

  assign p0_e = {bus.p0_taken_i, bus.p0_source_i,
                 bus.p0_target_i, bus.p0_is_call_i,
                 bus.p0_is_ret_i, bus.p0_is_jmp_i};
  assign p1_e = {bus.p1_taken_i, bus.p1_source_i,
                 bus.p1_target_i, bus.p1_is_call_i,
                 bus.p1_is_ret_i, bus.p1_is_jmp_i};

  assign p0m   = bus.p0_valid_i & bus.p0_mispredict_i;
  assign p1m   = bus.p1_valid_i & bus.p1_mispredict_i;
  assign idle  = (state_q == IDLE);

  // pipe1 is on the wrong path whenever pipe0 redirects
  assign cand0 = bus.p0_valid_i & ~bus.p0_mispredict_i;
  assign cand1 = bus.p1_valid_i & ~bus.p1_mispredict_i & ~p0m;

  assign fwd0  = ~rst_i & p0m;
  assign fwd1  = ~rst_i & p1m & ~p0m;
  assign pop   = ~rst_i & (count_q != '0) & ~p0m & ~p1m & idle;

  assign accept  = idle & ~bus.invalidate_i;
  assign n_cand  = {1'b0, cand0} + {1'b0, cand1};
  assign head_e  = mem_q[rd_ptr_q];
  assign first_e = cand0 ? p0_e : p1_e;
  assign wr_nxt  = wr_ptr_q + PW'(1);

  always_comb begin
    free_slots = CW'(FIFO_DEPTH) - CW'(count_q) + CW'(pop);
    n_push     = 2'd0;
    if (accept) begin
      if (CW'(n_cand) <= free_slots)
        n_push = n_cand;
      else
        n_push = free_slots[1:0];
    end
    n_drop = accept ? (n_cand - n_push) : 2'd0;
    push0  = (n_push != 2'd0);
    push1  = (n_push == 2'd2);
  end

  always_ff @(posedge clk_i) begin
    if (push0) mem_q[wr_ptr_q] <= first_e;
    if (push1) mem_q[wr_nxt]   <= p1_e;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.invalidate_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      wr_ptr_q <= wr_ptr_q + PW'(n_push);
      count_q  <= count_q + KW'(n_push) - KW'(pop);
    end
  end

  assign drop_sum = {1'b0, drop_q} + 17'(n_drop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      drop_q <= '0;
    else
      drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (bus.invalidate_i) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (bus.invalidate_i) begin
          idx_d = '0;
        end else if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_e   = head_e;
    out_req = 1'b0;
    out_vld = 1'b0;
    unique case (1'b1)
      fwd0: begin
        out_e   = p0_e;
        out_req = 1'b1;
        out_vld = 1'b1;
      end
      fwd1: begin
        out_e   = p1_e;
        out_req = 1'b1;
        out_vld = 1'b1;
      end
      pop:     out_vld = 1'b1;
      default: ;
    endcase
  end

  assign bus.branch_request_o      = out_req;
  assign bus.branch_is_taken_o     = out_vld & out_e.taken;
  assign bus.branch_is_not_taken_o = out_vld & ~out_e.taken;
  assign bus.branch_source_o       = out_vld ? out_e.source : '0;
  assign bus.branch_pc_o           = out_vld ? out_e.target : '0;
  assign bus.branch_is_call_o      = out_vld & out_e.is_call;
  assign bus.branch_is_ret_o       = out_vld & out_e.is_ret;
  assign bus.branch_is_jmp_o       = out_vld & out_e.is_jmp;

  assign bus.bht_clear_o     = (state_q == CLEAR);
  assign bus.bht_clear_idx_o = (state_q == CLEAR) ? idx_q : '0;
  assign bus.busy_o          = (state_q == CLEAR);
  assign bus.drop_count_o    = drop_q;

endmodule

// File: tb/tb_biriscv_npc_update_arb.sv
// Randomized bench for biriscv_npc_update_arb against a queue-based
// model of the arbitration, training FIFO and BHT clear walk.
`timescale 1ns/1ps
module tb_biriscv_npc_update_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  biriscv_npc_update_arb_if bus ();

  biriscv_npc_update_arb dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    bit        taken;
    bit [31:0] src;
    bit [31:0] tgt;
    bit [2:0]  ty;
  } rpt_t;

  rpt_t        q[$];
  int          drops;
  bit          clr;
  int          cidx;
  int          n_cmp;
  int          n_err;
  logic [96:0] exp_v;

  function automatic logic [96:0] dut_out();
    return {bus.branch_request_o, bus.branch_is_taken_o,
            bus.branch_is_not_taken_o, bus.branch_source_o,
            bus.branch_pc_o, bus.branch_is_call_o,
            bus.branch_is_ret_o, bus.branch_is_jmp_o,
            bus.bht_clear_o, bus.bht_clear_idx_o,
            bus.busy_o, bus.drop_count_o};
  endfunction

  function automatic rpt_t pipe_rpt(bit p);
    rpt_t r;
    if (!p) begin
      r.taken = bus.p0_taken_i;
      r.src   = bus.p0_source_i;
      r.tgt   = bus.p0_target_i;
      r.ty    = {bus.p0_is_call_i, bus.p0_is_ret_i, bus.p0_is_jmp_i};
    end else begin
      r.taken = bus.p1_taken_i;
      r.src   = bus.p1_source_i;
      r.tgt   = bus.p1_target_i;
      r.ty    = {bus.p1_is_call_i, bus.p1_is_ret_i, bus.p1_is_jmp_i};
    end
    return r;
  endfunction

  function automatic logic [69:0] pack_rpt(bit req, bit vld, rpt_t r);
    if (!vld) return '0;
    return {req, r.taken, ~r.taken, r.src, r.tgt, r.ty};
  endfunction

  function automatic rpt_t mk(bit tk, bit [31:0] s, bit [31:0] t);
    rpt_t r;
    r.taken = tk;
    r.src   = s;
    r.tgt   = t;
    r.ty    = 3'b000;
    return r;
  endfunction

  function automatic rpt_t rnd_rpt();
    rpt_t r;
    r.taken = 1'($urandom_range(0, 1));
    r.src   = $urandom;
    r.tgt   = $urandom;
    r.ty    = 3'($urandom_range(0, 7));
    return r;
  endfunction

  task automatic drive(bit p, bit v, bit m, rpt_t r);
    if (!p) begin
      bus.p0_valid_i      = v;
      bus.p0_mispredict_i = m;
      bus.p0_taken_i      = r.taken;
      bus.p0_source_i     = r.src;
      bus.p0_target_i     = r.tgt;
      {bus.p0_is_call_i, bus.p0_is_ret_i, bus.p0_is_jmp_i} = r.ty;
    end else begin
      bus.p1_valid_i      = v;
      bus.p1_mispredict_i = m;
      bus.p1_taken_i      = r.taken;
      bus.p1_source_i     = r.src;
      bus.p1_target_i     = r.tgt;
      {bus.p1_is_call_i, bus.p1_is_ret_i, bus.p1_is_jmp_i} = r.ty;
    end
  endtask

  task automatic idle_inputs();
    rpt_t z;
    z = mk(1'b0, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, z);
    drive(1'b1, 1'b0, 1'b0, z);
    bus.invalidate_i = 1'b0;
  endtask

  // Expected outputs for the current cycle from model state and inputs
  task automatic model_expect();
    bit          p0m;
    bit          p1m;
    logic [69:0] br;
    p0m = bus.p0_valid_i && bus.p0_mispredict_i;
    p1m = bus.p1_valid_i && bus.p1_mispredict_i;
    br  = '0;
    if (rst) begin
      exp_v = '0;
    end else begin
      if (p0m)
        br = pack_rpt(1'b1, 1'b1, pipe_rpt(1'b0));
      else if (p1m)
        br = pack_rpt(1'b1, 1'b1, pipe_rpt(1'b1));
      else if (!clr && q.size() > 0)
        br = pack_rpt(1'b0, 1'b1, q[0]);
      exp_v = {br, clr, clr ? 9'(cidx) : 9'd0, clr, 16'(drops)};
    end
  endtask

  // Clock-edge update of the model
  task automatic model_step();
    bit   p0m;
    bit   p1m;
    bit   was_clr;
    rpt_t c[$];
    if (rst) begin
      q.delete();
      drops = 0;
      clr   = 1'b0;
      cidx  = 0;
      return;
    end
    p0m     = bus.p0_valid_i && bus.p0_mispredict_i;
    p1m     = bus.p1_valid_i && bus.p1_mispredict_i;
    was_clr = clr;
    if (!p0m && !p1m && !clr && q.size() > 0)
      void'(q.pop_front());
    if (bus.p0_valid_i && !p0m)
      c.push_back(pipe_rpt(1'b0));
    if (!p0m && bus.p1_valid_i && !p1m)
      c.push_back(pipe_rpt(1'b1));
    if (bus.invalidate_i) begin
      q.delete();
      clr  = 1'b1;
      cidx = 0;
    end else if (clr) begin
      if (cidx == 511) clr = 1'b0;
      else cidx++;
    end
    if (!was_clr && !bus.invalidate_i) begin
      foreach (c[i]) begin
        if (q.size() < 4) q.push_back(c[i]);
        else if (drops < 65535) drops++;
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      model_expect();
      n_cmp++;
      if (dut_out() !== exp_v || exp_v !== '0) begin
        n_err++;
        $display("FAIL reset cyc=%0d got=%h exp=%h", i, dut_out(), exp_v);
      end
      advance();
    end
    rst = 1'b0;
    @(negedge clk);
    model_expect();
    n_cmp++;
    if (dut_out() !== exp_v) begin
      n_err++;
      $display("FAIL reset_release got=%h exp=%h", dut_out(), exp_v);
    end
    advance();
  endtask

  task automatic test_single_training();
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      if (i == 0) drive(1'b0, 1'b1, 1'b0, mk(1'b1, 32'h100, 32'h200));
      @(negedge clk);
      model_expect();
      n_cmp++;
      if (dut_out() !== exp_v) begin
        n_err++;
        $display("FAIL single_train cyc=%0d got=%h exp=%h", i, dut_out(), exp_v);
      end
      if (i == 1) begin
        n_cmp++;
        if ({bus.branch_request_o, bus.branch_is_taken_o,
             bus.branch_source_o, bus.branch_pc_o} !==
            {1'b0, 1'b1, 32'h100, 32'h200}) begin
          n_err++;
          $display("FAIL single_train_lat got=%b/%b/%h/%h exp=0/1/100/200",
                   bus.branch_request_o, bus.branch_is_taken_o,
                   bus.branch_source_o, bus.branch_pc_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_dual_mispredict();
    for (int i = 0; i < 3; i++) begin
      idle_inputs();
      if (i == 0) begin
        drive(1'b0, 1'b1, 1'b1, mk(1'b1, 32'h100, 32'h300));
        drive(1'b1, 1'b1, 1'b1, mk(1'b0, 32'h104, 32'h400));
      end
      @(negedge clk);
      model_expect();
      n_cmp++;
      if (dut_out() !== exp_v) begin
        n_err++;
        $display("FAIL dual_misp cyc=%0d got=%h exp=%h", i, dut_out(), exp_v);
      end
      if (i == 0) begin
        n_cmp++;
        if ({bus.branch_request_o, bus.branch_source_o,
             bus.drop_count_o} !== {1'b1, 32'h100, 16'd0}) begin
          n_err++;
          $display("FAIL dual_misp_sel got=%b/%h/%0d exp=1/100/0",
                   bus.branch_request_o, bus.branch_source_o,
                   bus.drop_count_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_burst();
    for (int i = 0; i < 12; i++) begin
      idle_inputs();
      if (i < 5) begin
        drive(1'b0, 1'b1, 1'b0, rnd_rpt());
        drive(1'b1, 1'b1, 1'b0, rnd_rpt());
      end
      @(negedge clk);
      model_expect();
      n_cmp++;
      if (dut_out() !== exp_v) begin
        n_err++;
        $display("FAIL burst cyc=%0d got=%h exp=%h", i, dut_out(), exp_v);
      end
      advance();
    end
  endtask

  task automatic test_mispredict_hold();
    for (int i = 0; i < 6; i++) begin
      idle_inputs();
      if (i == 0) begin
        drive(1'b0, 1'b1, 1'b0, rnd_rpt());
        drive(1'b1, 1'b1, 1'b0, rnd_rpt());
      end
      if (i == 1) drive(1'b1, 1'b1, 1'b1, rnd_rpt());
      if (i == 2) drive(1'b0, 1'b1, 1'b1, rnd_rpt());
      @(negedge clk);
      model_expect();
      n_cmp++;
      if (dut_out() !== exp_v) begin
        n_err++;
        $display("FAIL misp_hold cyc=%0d got=%h exp=%h", i, dut_out(), exp_v);
      end
      advance();
    end
  endtask

  task automatic test_walk();
    for (int i = -2; i < 668; i++) begin
      idle_inputs();
      if (i < 0) begin
        drive(1'b0, 1'b1, 1'b0, rnd_rpt());
        drive(1'b1, 1'b1, 1'b0, rnd_rpt());
      end
      if (i == 0 || i == 150) bus.invalidate_i = 1'b1;
      if (i % 7 == 3) begin
        drive(1'b0, 1'b1, 1'b0, rnd_rpt());
        drive(1'b1, 1'b1, 1'b0, rnd_rpt());
      end
      if (i == 60) drive(1'b0, 1'b1, 1'b1, rnd_rpt());
      if (i == 61) drive(1'b1, 1'b1, 1'b1, rnd_rpt());
      @(negedge clk);
      model_expect();
      n_cmp++;
      if (dut_out() !== exp_v) begin
        n_err++;
        $display("FAIL walk cyc=%0d got=%h exp=%h", i, dut_out(), exp_v);
      end
      if (i == 1 || i == 151 || i == 662 || i == 663) begin
        n_cmp++;
        if ({bus.busy_o, bus.bht_clear_idx_o} !==
            ((i == 663) ? 10'd0 : {1'b1, (i == 662) ? 9'd511 : 9'd0})) begin
          n_err++;
          $display("FAIL walk_bound cyc=%0d got busy=%b idx=%0d",
                   i, bus.busy_o, bus.bht_clear_idx_o);
        end
      end
      advance();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      drive(1'b0, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), rnd_rpt());
      drive(1'b1, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 4) == 0), rnd_rpt());
      bus.invalidate_i = ($urandom_range(0, 299) == 0);
      @(negedge clk);
      model_expect();
      n_cmp++;
      if (dut_out() !== exp_v) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%h exp=%h", i, dut_out(), exp_v);
      end
      advance();
    end
    // let any walk started above finish before the next scenario
    idle_inputs();
    while (clr) advance();
  endtask

  task automatic test_reset_midwalk();
    bit reached;
    reached = 1'b0;
    for (int i = 0; i < 300 && !reached; i++) begin
      idle_inputs();
      if (i == 0) bus.invalidate_i = 1'b1;
      else drive(1'b0, 1'b1, 1'b0, rnd_rpt());
      @(negedge clk);
      model_expect();
      n_cmp++;
      if (dut_out() !== exp_v) begin
        n_err++;
        $display("FAIL rst_walk cyc=%0d got=%h exp=%h", i, dut_out(), exp_v);
      end
      advance();
      if (clr && cidx == 100) reached = 1'b1;
    end
    n_cmp++;
    if (!reached || bus.bht_clear_idx_o !== 9'd100) begin
      n_err++;
      $display("FAIL rst_walk_reach got idx=%0d exp=100", bus.bht_clear_idx_o);
    end
    idle_inputs();
    rst = 1'b1;
    #1;
    model_step();
    n_cmp++;
    if ({bus.bht_clear_o, bus.busy_o} !== 2'b00) begin
      n_err++;
      $display("FAIL rst_async got=%b%b exp=00", bus.bht_clear_o, bus.busy_o);
    end
    for (int i = 0; i < 5; i++) begin
      if (i == 2) rst = 1'b0;
      @(negedge clk);
      model_expect();
      n_cmp++;
      if (dut_out() !== exp_v) begin
        n_err++;
        $display("FAIL rst_after cyc=%0d got=%h exp=%h", i, dut_out(), exp_v);
      end
      if (i == 4) begin
        n_cmp++;
        if ({bus.busy_o, bus.drop_count_o} !== 17'd0) begin
          n_err++;
          $display("FAIL rst_idle got busy=%b drops=%0d exp=0/0",
                   bus.busy_o, bus.drop_count_o);
        end
      end
      advance();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    drops = 0;
    clr   = 1'b0;
    cidx  = 0;
    q.delete();
    idle_inputs();
    test_reset();
    test_single_training();
    test_dual_mispredict();
    test_burst();
    test_mispredict_hold();
    test_walk();
    test_random();
    test_reset_midwalk();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
